// File: rtl/mirror_cal_pkg.sv
// -----------------------------------------------------------------------------
// mirror_cal_pkg
// Shared types and constants for the current-mirror calibration controller.
//   cal_state_t : controller FSM states
//   CFG_DEFAULT : nominal mirror trim applied out of reset
//   NSAMP       : comparator samples per majority vote
//   CODE_MAX    : highest (lowest-gain) mirror code
//   maj3()      : 3-input majority helper
// -----------------------------------------------------------------------------
package mirror_cal_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } cal_state_t;

    localparam logic [1:0] CFG_DEFAULT = 2'b01;
    localparam int         NSAMP       = 3;
    localparam logic [1:0] CODE_MAX    = 2'b11;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mirror_cal_vote.sv
// -----------------------------------------------------------------------------
// mirror_cal_vote
// Comparator sample history with a 3-way majority vote.
//   clk       in  block clock
//   rstb      in  asynchronous active-low reset
//   clr       in  wipe the stored history (start of a new vote)
//   shift_en  in  shift sample_in into the history this cycle
//   sample_in in  current comparator sample
//   vote      out majority of the current sample and the two stored ones
// The window is the live sample plus the two previous ones, so the vote is
// valid in the same cycle as the third sample and the decision can be taken
// on the edge that captures it.
// -----------------------------------------------------------------------------
module mirror_cal_vote
    import mirror_cal_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic clr,
    input  logic shift_en,
    input  logic sample_in,
    output logic vote
);

    localparam int HIST_W = NSAMP - 1;

    logic [HIST_W-1:0] hist_reg;

    genvar gi;
    generate
        for (gi = 0; gi < HIST_W; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rstb) begin
                    if (!rstb) begin
                        hist_reg[gi] <= 1'b0;
                    end else if (clr) begin
                        hist_reg[gi] <= 1'b0;
                    end else if (shift_en) begin
                        hist_reg[gi] <= sample_in;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rstb) begin
                    if (!rstb) begin
                        hist_reg[gi] <= 1'b0;
                    end else if (clr) begin
                        hist_reg[gi] <= 1'b0;
                    end else if (shift_en) begin
                        hist_reg[gi] <= hist_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign vote = maj3(sample_in, hist_reg[0], hist_reg[1]);

endmodule

// File: rtl/mirror_cal_ctrl.sv
// -----------------------------------------------------------------------------
// mirror_cal_ctrl
// Linear-search calibration of the 2-bit current-mirror trim. Codes are tried
// from 00 (highest gain) upwards; each code is allowed SETTLE_CYC cycles to
// settle, then the comparator is majority-voted over three cycles. The first
// code whose current is not above target is kept. Firmware may force the code.
//   clk       in  block clock
//   rstb      in  asynchronous active-low reset
//   cal_start in  single-cycle calibration request (ignored while busy)
//   cmp_hi    in  comparator flag, 1 = mirror current above target
//   ovr_en    in  force cfg_mirr to ovr_code (aborts a running search)
//   ovr_code  in  override trim code
//   cfg_mirr  out registered trim code to the mirror
//   cal_busy  out calibration in progress
//   cal_done  out last calibration completed (level)
//   cal_fail  out last search ended at CODE_MAX with current still high
//   cal_code  out result of the last completed calibration
// -----------------------------------------------------------------------------
module mirror_cal_ctrl
    import mirror_cal_pkg::*;
#(
    parameter int SETTLE_CYC = 16
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       cal_start,
    input  logic       cmp_hi,
    input  logic       ovr_en,
    input  logic [1:0] ovr_code,
    output logic [1:0] cfg_mirr,
    output logic       cal_busy,
    output logic       cal_done,
    output logic       cal_fail,
    output logic [1:0] cal_code
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [1:0] SAMP_LAST   = 2'(NSAMP - 1);

    cal_state_t state_reg,    state_next;
    logic [7:0] cnt_reg,      cnt_next;
    logic [1:0] samp_cnt_reg, samp_cnt_next;
    logic [1:0] cfg_reg,      cfg_next;
    logic [1:0] code_reg,     code_next;
    logic       busy_reg,     busy_next;
    logic       done_reg,     done_next;
    logic       fail_reg,     fail_next;

    logic vote_clr;
    logic vote_shift;
    logic vote;

    mirror_cal_vote u_vote (
        .clk       (clk),
        .rstb      (rstb),
        .clr       (vote_clr),
        .shift_en  (vote_shift),
        .sample_in (cmp_hi),
        .vote      (vote)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            samp_cnt_reg <= 2'd0;
            cfg_reg      <= CFG_DEFAULT;
            code_reg     <= CFG_DEFAULT;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            samp_cnt_reg <= samp_cnt_next;
            cfg_reg      <= cfg_next;
            code_reg     <= code_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            fail_reg     <= fail_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        samp_cnt_next = samp_cnt_reg;
        cfg_next      = cfg_reg;
        code_next     = code_reg;
        busy_next     = busy_reg;
        done_next     = done_reg;
        fail_next     = fail_reg;
        vote_clr      = 1'b0;
        vote_shift    = 1'b0;

        if (ovr_en) begin
            // Override has priority over everything, including a same-cycle
            // cal_start. Result registers are deliberately left untouched.
            cfg_next   = ovr_code;
            state_next = IDLE;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cal_start) begin
                        cfg_next   = 2'b00;
                        done_next  = 1'b0;
                        fail_next  = 1'b0;
                        busy_next  = 1'b1;
                        cnt_next   = SETTLE_LOAD;
                        state_next = SETTLE;
                    end
                end

                SETTLE: begin
                    if (cnt_reg == 8'd0) begin
                        // Fresh history so a vote never mixes two codes.
                        vote_clr      = 1'b1;
                        samp_cnt_next = 2'd0;
                        state_next    = SAMPLE;
                    end else begin
                        cnt_next = cnt_reg - 8'd1;
                    end
                end

                SAMPLE: begin
                    vote_shift = 1'b1;
                    if (samp_cnt_reg == SAMP_LAST) begin
                        if (!vote) begin
                            code_next  = cfg_reg;
                            done_next  = 1'b1;
                            busy_next  = 1'b0;
                            state_next = IDLE;
                        end else if (cfg_reg == CODE_MAX) begin
                            code_next  = CODE_MAX;
                            done_next  = 1'b1;
                            fail_next  = 1'b1;
                            busy_next  = 1'b0;
                            state_next = IDLE;
                        end else begin
                            // Next code and settle reload land on the same edge.
                            cfg_next   = cfg_reg + 2'd1;
                            cnt_next   = SETTLE_LOAD;
                            state_next = SETTLE;
                        end
                    end else begin
                        samp_cnt_next = samp_cnt_reg + 2'd1;
                    end
                end

                default: begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

    assign cfg_mirr = cfg_reg;
    assign cal_busy = busy_reg;
    assign cal_done = done_reg;
    assign cal_fail = fail_reg;
    assign cal_code = code_reg;

endmodule

// File: tb/tb_mirror_cal_ctrl.sv
module tb_mirror_cal_ctrl;

    localparam int S    = 4;
    localparam int CODE = S + 3;

    logic       clk;
    logic       rstb;
    logic       cal_start;
    logic       cmp_hi;
    logic       ovr_en;
    logic [1:0] ovr_code;
    logic [1:0] cfg_mirr;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_fail;
    logic [1:0] cal_code;

    mirror_cal_ctrl #(.SETTLE_CYC(S)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .cal_start (cal_start),
        .cmp_hi    (cmp_hi),
        .ovr_en    (ovr_en),
        .ovr_code  (ovr_code),
        .cfg_mirr  (cfg_mirr),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .cal_fail  (cal_fail),
        .cal_code  (cal_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } mirr_exp_t;

    typedef struct {
        logic [1:0] code;
        logic       fail;
        int         cyc;
    } done_exp_t;

    mirr_exp_t mirr_q[$];
    done_exp_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    int   e_cyc    = -1000;
    int   cmp_mode = 0;
    logic mon_on   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Comparator stimulus, updated away from the sampling edge.
    // Mode 3 drives the majority-filter pattern keyed by edges since start.
    function automatic logic pattern(input int t);
        case (t)
            4:  return 1'b1;
            5:  return 1'b0;
            6:  return 1'b1;
            11: return 1'b0;
            12: return 1'b1;
            13: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always @(negedge clk) begin
        case (cmp_mode)
            0: cmp_hi = (cfg_mirr < 2'd2);
            1: cmp_hi = 1'b0;
            2: cmp_hi = 1'b1;
            default: cmp_hi = pattern(cyc - e_cyc);
        endcase
    end

    // Monitor: every cfg_mirr change and every cal_done rise is matched
    // against the next expected entry.
    logic [1:0] prev_mirr = 2'b01;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (cfg_mirr !== prev_mirr) begin
                if (mirr_q.size() == 0) begin
                    chk("mirr_unexpected_change", int'(cfg_mirr), int'(prev_mirr));
                end else begin
                    mirr_exp_t m;
                    m = mirr_q.pop_front();
                    chk("mirr_code", int'(cfg_mirr), int'(m.code));
                    chk("mirr_cycle", cyc, m.cyc);
                end
            end
            if (cal_done && !prev_done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("done_code", int'(cal_code), int'(d.code));
                    chk("done_fail", int'(cal_fail), int'(d.fail));
                    chk("done_busy", int'(cal_busy), 0);
                end
                $display("done: code=%0d fail=%0d cyc=%0d", cal_code, cal_fail, cyc);
            end
        end
        prev_mirr = cfg_mirr;
        prev_done = cal_done;
    end

    task automatic push_m(input logic [1:0] code, input int at);
        mirr_exp_t m;
        m.code = code;
        m.cyc  = at;
        mirr_q.push_back(m);
    endtask

    task automatic push_d(input logic [1:0] code, input logic fail, input int at);
        done_exp_t d;
        d.code = code;
        d.fail = fail;
        d.cyc  = at;
        done_q.push_back(d);
    endtask

    // Pulse cal_start; returns at the negedge following the sampling edge E.
    task automatic start_cal();
        @(negedge clk);
        cal_start = 1'b1;
        e_cyc     = cyc + 1;
        @(negedge clk);
        cal_start = 1'b0;
        chk("busy_after_start", int'(cal_busy), 1);
        $display("start: E=%0d mode=%0d", e_cyc, cmp_mode);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (cal_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cal_busy) chk("wait_idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rstb      = 1'b1;
        cal_start = 1'b0;
        ovr_en    = 1'b0;
        ovr_code  = 2'b00;
        #2 rstb   = 1'b0;

        // Reset defaults
        repeat (3) @(negedge clk);
        chk("rst_cfg", int'(cfg_mirr), 1);
        chk("rst_code", int'(cal_code), 1);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel_cfg", int'(cfg_mirr), 1);
        chk("rel_code", int'(cal_code), 1);
        chk("rel_busy", int'(cal_busy), 0);
        chk("rel_done", int'(cal_done), 0);
        chk("rel_fail", int'(cal_fail), 0);
        $display("reset: cfg=%0d code=%0d", cfg_mirr, cal_code);
        mon_on = 1'b1;

        // Search stops at code 2
        cmp_mode = 0;
        push_m(2'b00, cyc + 2);
        push_m(2'b01, cyc + 2 + CODE);
        push_m(2'b10, cyc + 2 + 2 * CODE);
        push_d(2'b10, 1'b0, cyc + 2 + 3 * CODE);
        start_cal();
        wait_idle(200);

        // Immediate pass
        cmp_mode = 1;
        push_m(2'b00, cyc + 2);
        push_d(2'b00, 1'b0, cyc + 2 + CODE);
        start_cal();
        wait_idle(200);

        // Fail case (already at 00, so no change on the start edge)
        cmp_mode = 2;
        push_m(2'b01, cyc + 2 + CODE);
        push_m(2'b10, cyc + 2 + 2 * CODE);
        push_m(2'b11, cyc + 2 + 3 * CODE);
        push_d(2'b11, 1'b1, cyc + 2 + 4 * CODE);
        start_cal();
        wait_idle(200);
        chk("fail_level", int'(cal_fail), 1);
        chk("fail_cfg_hold", int'(cfg_mirr), 3);

        // Majority filtering: 1,0,1 advances, 0,1,0 stops
        cmp_mode = 3;
        push_m(2'b00, cyc + 2);
        push_m(2'b01, cyc + 2 + CODE);
        push_d(2'b01, 1'b0, cyc + 2 + 2 * CODE);
        start_cal();
        wait_idle(200);
        chk("maj_fail_clear", int'(cal_fail), 0);

        // Override abort during SETTLE
        cmp_mode = 2;
        push_m(2'b00, cyc + 2);
        start_cal();
        repeat (2) @(negedge clk);
        ovr_en   = 1'b1;
        ovr_code = 2'b10;
        push_m(2'b10, cyc + 1);
        @(negedge clk);
        chk("ovr_busy", int'(cal_busy), 0);
        chk("ovr_done_kept", int'(cal_done), 0);
        chk("ovr_fail_kept", int'(cal_fail), 0);
        chk("ovr_code_kept", int'(cal_code), 1);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        chk("ovr_start_blocked", int'(cal_busy), 0);
        ovr_code = 2'b11;
        push_m(2'b11, cyc + 1);
        @(negedge clk);
        ovr_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("ovr_release_hold", int'(cfg_mirr), 3);
        chk("ovr_release_busy", int'(cal_busy), 0);
        $display("override: cfg=%0d busy=%0d", cfg_mirr, cal_busy);

        // cal_start while busy is ignored
        cmp_mode = 0;
        push_m(2'b00, cyc + 2);
        push_m(2'b01, cyc + 2 + CODE);
        push_m(2'b10, cyc + 2 + 2 * CODE);
        push_d(2'b10, 1'b0, cyc + 2 + 3 * CODE);
        start_cal();
        repeat (3) @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        wait_idle(200);

        // Reset pulse mid-search
        cmp_mode = 2;
        push_m(2'b00, cyc + 2);
        push_m(2'b01, cyc + 2 + CODE);
        push_m(2'b10, cyc + 2 + 2 * CODE);
        start_cal();
        repeat (16) @(negedge clk);
        push_m(2'b01, cyc + 1);
        rstb = 1'b0;
        #1;
        chk("arst_cfg", int'(cfg_mirr), 1);
        chk("arst_code", int'(cal_code), 1);
        chk("arst_busy", int'(cal_busy), 0);
        chk("arst_done", int'(cal_done), 0);
        chk("arst_fail", int'(cal_fail), 0);
        $display("async reset: cfg=%0d code=%0d", cfg_mirr, cal_code);
        @(negedge clk);
        rstb = 1'b1;
        repeat (S + 6) @(negedge clk);
        chk("post_rst_busy", int'(cal_busy), 0);

        chk("mirr_q_empty", mirr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
